// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared op-code constants for the register file and its ALU.
package reg_file_pkg;

    localparam int REG_FILE_OP_W = 4;

    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_NOP   = 4'd0;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_CLEAR = 4'd1;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_FILL  = 4'd2;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_WRITE = 4'd3;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_INC   = 4'd4;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_DEC   = 4'd5;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_INV   = 4'd6;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_BOOL  = 4'd7;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_SHL   = 4'd8;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_SHR   = 4'd9;
    localparam logic [REG_FILE_OP_W-1:0] REG_FILE_OP_MOVE  = 4'd10;

endpackage

// File: rtl/reg_file_alu.sv
// reg_file_alu: combinational next-value and carry function for the one
// register selected by the current operation. Unused op codes pass the
// destination value through and request no flag updates.
module reg_file_alu
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [REG_FILE_OP_W-1:0] op,
    input  logic [DATA_W-1:0]        dst_val,
    input  logic [DATA_W-1:0]        src_val,
    input  logic [DATA_W-1:0]        lane_val,
    output logic [DATA_W-1:0]        next_val,
    output logic                     carry,
    output logic                     carry_upd,
    output logic                     zero_upd
);

    // Decode the op into the new register value and which flags it touches.
    always_comb begin
        next_val  = dst_val;
        carry     = 1'b0;
        carry_upd = 1'b0;
        zero_upd  = 1'b1;
        case (op)
            REG_FILE_OP_NOP:   zero_upd = 1'b0;
            REG_FILE_OP_CLEAR: next_val = '0;
            REG_FILE_OP_FILL:  next_val = '1;
            REG_FILE_OP_WRITE: next_val = lane_val;
            REG_FILE_OP_INC: begin
                next_val  = dst_val + DATA_W'(1);
                carry     = &dst_val;
                carry_upd = 1'b1;
            end
            REG_FILE_OP_DEC: begin
                next_val  = dst_val - DATA_W'(1);
                carry     = ~|dst_val;
                carry_upd = 1'b1;
            end
            REG_FILE_OP_INV:   next_val = ~dst_val;
            REG_FILE_OP_BOOL:  next_val = {{(DATA_W-1){1'b0}}, |dst_val};
            REG_FILE_OP_SHL: begin
                next_val  = {dst_val[DATA_W-2:0], 1'b0};
                carry     = dst_val[DATA_W-1];
                carry_upd = 1'b1;
            end
            REG_FILE_OP_SHR: begin
                next_val  = {1'b0, dst_val[DATA_W-1:1]};
                carry     = dst_val[0];
                carry_upd = 1'b1;
            end
            REG_FILE_OP_MOVE:  next_val = src_val;
            default:           zero_upd = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: REG_COUNT x DATA_W register file with one op per clock on the
// selected register, a tri-state read port onto any lane of io_bus and a
// packed view of all registers. Define REG_FILE_FLAGS_EN to add the
// o_zero / o_carry flag outputs and their flip-flops.
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int REG_COUNT = 4,
    parameter  int LANES     = 3,
    localparam int SEL_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [REG_FILE_OP_W-1:0]    i_op,
    input  logic [SEL_W-1:0]            i_op_sel,
    input  logic [SEL_W-1:0]            i_src_sel,
    input  logic [LANE_W-1:0]           i_wr_lane,
    input  logic                        i_rd_en,
    input  logic [SEL_W-1:0]            i_rd_sel,
    input  logic [LANE_W-1:0]           i_rd_lane,
    inout  wire  [LANES*DATA_W-1:0]     io_bus,
    output logic [REG_COUNT*DATA_W-1:0] o_regs
`ifdef REG_FILE_FLAGS_EN
    ,
    output logic                        o_zero,
    output logic                        o_carry
`endif
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    logic [DATA_W-1:0] dst_val;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] lane_val;
    logic              dst_hit;
    logic              src_hit;
    logic              rd_hit;
    logic              op_valid;
    logic              rd_drive;

    logic [DATA_W-1:0] alu_next;
    logic              alu_carry;
    logic              alu_carry_upd;
    logic              alu_zero_upd;

    // Look up destination, source and read registers; out-of-range selects miss.
    always_comb begin
        dst_val = '0;
        src_val = '0;
        rd_val  = '0;
        dst_hit = 1'b0;
        src_hit = 1'b0;
        rd_hit  = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (SEL_W'(r) == i_op_sel) begin
                dst_val = regs_q[r];
                dst_hit = 1'b1;
            end
            if (SEL_W'(r) == i_src_sel) begin
                src_val = regs_q[r];
                src_hit = 1'b1;
            end
            if (SEL_W'(r) == i_rd_sel) begin
                rd_val = regs_q[r];
                rd_hit = 1'b1;
            end
        end
    end

    // Pick the bus lane that WRITE samples; a lane index past the bus reads as zero.
    always_comb begin
        lane_val = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LANE_W'(k) == i_wr_lane) begin
                lane_val = io_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    assign op_valid = dst_hit && ((i_op != REG_FILE_OP_MOVE) || src_hit);
    assign rd_drive = i_reset_n && i_rd_en && rd_hit;

    reg_file_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op        (i_op),
        .dst_val   (dst_val),
        .src_val   (src_val),
        .lane_val  (lane_val),
        .next_val  (alu_next),
        .carry     (alu_carry),
        .carry_upd (alu_carry_upd),
        .zero_upd  (alu_zero_upd)
    );

    // Register storage: reset clears everything, otherwise only the selected register loads.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (op_valid && (SEL_W'(r) == i_op_sel)) begin
                    regs_q[r] <= alu_next;
                end
            end
        end
    end

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_regs_out
        assign o_regs[r*DATA_W +: DATA_W] = regs_q[r];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane_drive
        assign io_bus[k*DATA_W +: DATA_W] =
            (rd_drive && (i_rd_lane == LANE_W'(k))) ? rd_val : {DATA_W{1'bz}};
    end

`ifdef REG_FILE_FLAGS_EN
    // Flags follow the result of the last accepted op that is allowed to touch them.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_zero  <= 1'b0;
            o_carry <= 1'b0;
        end else if (op_valid) begin
            if (alu_zero_upd) begin
                o_zero <= (alu_next == '0);
            end
            if (alu_carry_upd) begin
                o_carry <= alu_carry;
            end
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{alu_carry, alu_carry_upd, alu_zero_upd};
`endif

endmodule
